// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_stage
// Purpose  : Pipelined RV32/RV64 immediate extender behind a 2-entry skid
//            buffer. Optional LUI+ADDI fusion when IMM_FUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_stage #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_immsrc,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_fuse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             out_fused,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int SH_W = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             fused;
  } beat_t;

  beat_t            slot0_q, slot0_d, slot1_q, slot1_d;
  beat_t            new_beat, beat_a, beat_b;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             accept, pop, push_a, push_b, hold_mode;
  logic             unused_opcode;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign accept        = in_valid & in_ready_q;
  assign pop           = (cnt_q != 2'd0) & out_ready;
  assign unused_opcode = ^in_instr[6:0];

  always_comb begin
    new_beat     = '0;
    new_beat.tag = in_tag;
    case (in_immsrc)
      3'd0: new_beat.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      3'd1: new_beat.imm[SH_W-1:0] = in_instr[20 +: SH_W];
      3'd2: new_beat.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      3'd3: new_beat.imm = sext32({in_instr[31:12], 12'b0});
      3'd4: new_beat.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                   in_instr[20], in_instr[30:21], 1'b0});
      3'd5: new_beat.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8], 1'b0});
      3'd6: new_beat.imm[4:0] = in_instr[19:15];
      default: new_beat.illegal = 1'b1;
    endcase
  end

`ifdef IMM_FUSE_EN
  typedef enum logic [0:0] {S_IDLE, S_HOLD_U} fuse_state_e;

  fuse_state_e state_q, state_d;
  beat_t       held_q, held_d;
  logic        fuse_u, fuse_i;

  assign fuse_u = in_fuse & (in_immsrc == 3'd3);
  assign fuse_i = in_fuse & (in_immsrc == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push_a  = 1'b0;
    push_b  = 1'b0;
    beat_a  = new_beat;
    beat_b  = new_beat;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (fuse_u) begin
            state_d = S_HOLD_U;
            held_d  = new_beat;
          end else begin
            push_a = 1'b1;
          end
        end
        S_HOLD_U: begin
          push_a = 1'b1;
          if (fuse_i) begin
            beat_a.imm   = held_q.imm + new_beat.imm;
            beat_a.fused = 1'b1;
            state_d      = S_IDLE;
          end else begin
            // Release the held U first; a new fusable U takes its place.
            beat_a = held_q;
            if (fuse_u) begin
              held_d = new_beat;
            end else begin
              push_b  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  assign hold_mode = (state_d == S_HOLD_U);
`else
  logic unused_fuse;

  assign unused_fuse = in_fuse;
  assign push_a      = accept;
  assign push_b      = 1'b0;
  assign beat_a      = new_beat;
  assign beat_b      = new_beat;
  assign hold_mode   = 1'b0;
`endif

  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cnt_d     = cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (push_a) begin
      if (cnt_d == 2'd0) slot0_d = beat_a;
      else               slot1_d = beat_a;
      cnt_d = cnt_d + 2'd1;
    end
    if (push_b) begin
      if (cnt_d == 2'd0) slot0_d = beat_b;
      else               slot1_d = beat_b;
      cnt_d = cnt_d + 2'd1;
    end
    if (flush) begin
      cnt_d = 2'd0;
    end
    if (accept && new_beat.illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end
    // A held U may release two beats at once, so it needs an empty buffer.
    in_ready_d = hold_mode ? (cnt_d == 2'd0) : (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (cnt_q != 2'd0);
  assign out_imm       = slot0_q.imm;
  assign out_tag       = slot0_q.tag;
  assign out_illegal   = slot0_q.illegal;
  assign out_fused     = slot0_q.fused;
  assign illegal_count = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
`default_nettype none
// Testbench for imm_extend_stage (XLEN=64); fusion sequences compile in
// when IMM_FUSE_EN is defined.
module tb_imm_extend_stage;
  localparam int XLEN  = 64;
  localparam int TAG_W = 6;
  localparam int CNT_W = 8;
  localparam int NV    = 16;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, in_fuse;
  logic [2:0]       in_immsrc;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_illegal, out_fused;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] illegal_count;

  imm_extend_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_immsrc(in_immsrc),
    .in_instr(in_instr), .in_tag(in_tag), .in_fuse(in_fuse),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal), .out_fused(out_fused),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [5:0]  tag;
    logic        ill;
    logic        fused;
  } exp_t;

  vec_t vecs [NV];
  exp_t sbq [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ill_seen = 0;
  bit   sb_en = 1'b0;

  function automatic exp_t mk(input logic [63:0] imm, input logic [5:0] tag,
                              input logic ill, input logic fused);
    exp_t e;
    e.imm = imm; e.tag = tag; e.ill = ill; e.fused = fused;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every beat the consumer takes must match the expected queue head.
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: actual imm 0x%0h tag %0d, required no beat", out_imm, out_tag);
      end else begin
        mon_e = sbq.pop_front();
        if ({out_imm, out_tag, out_illegal, out_fused} !== {mon_e.imm, mon_e.tag, mon_e.ill, mon_e.fused}) begin
          errors++;
          $display("FAIL sb_beat: actual imm 0x%0h tag %0d ill %0b fused %0b, required imm 0x%0h tag %0d ill %0b fused %0b",
                   out_imm, out_tag, out_illegal, out_fused, mon_e.imm, mon_e.tag, mon_e.ill, mon_e.fused);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] src, input logic [31:0] instr, input logic [5:0] tag,
                      input logic fuse, input bit push_exp, input exp_t e);
    bit rdy;
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_immsrc = src;
    in_instr  = instr;
    in_tag    = tag;
    in_fuse   = fuse;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    in_fuse  = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: actual not accepted, required accepted (tag %0d)", tag);
    end else begin
      if (src == 3'd7) ill_seen++;
      if (push_exp) sbq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(sbq.size()), 64'd0);
    @(negedge clk);
    check({name, "_idle"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_tag", {58'd0, out_tag}, 64'd0);
    check("rst_flags", {62'd0, out_illegal, out_fused}, 64'd0);
    check("rst_illegal_count", {56'd0, illegal_count}, 64'd0);
    reset = 1'b0;
    sbq.delete();
    ill_seen = 0;
    check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_fuse = 1'b0;
    in_immsrc = 3'd0; in_instr = 32'd0; in_tag = '0; out_ready = 1'b0;

    vecs[0]  = '{3'd0, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{3'd0, 32'h00100093, 64'h0000_0000_0000_0001, 1'b0};
    vecs[2]  = '{3'd0, 32'h7FF00093, 64'h0000_0000_0000_07FF, 1'b0};
    vecs[3]  = '{3'd1, 32'h43F0D093, 64'h0000_0000_0000_003F, 1'b0};
    vecs[4]  = '{3'd1, 32'hFFF05093, 64'h0000_0000_0000_003F, 1'b0};
    vecs[5]  = '{3'd2, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[6]  = '{3'd2, 32'h0020A423, 64'h0000_0000_0000_0008, 1'b0};
    vecs[7]  = '{3'd3, 32'h123452B7, 64'h0000_0000_1234_5000, 1'b0};
    vecs[8]  = '{3'd3, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[9]  = '{3'd4, 32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[10] = '{3'd4, 32'h008000EF, 64'h0000_0000_0000_0008, 1'b0};
    vecs[11] = '{3'd5, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[12] = '{3'd5, 32'h00000863, 64'h0000_0000_0000_0010, 1'b0};
    vecs[13] = '{3'd6, 32'h340FD073, 64'h0000_0000_0000_001F, 1'b0};
    vecs[14] = '{3'd6, 32'hFFF0D073, 64'h0000_0000_0000_0001, 1'b0};
    vecs[15] = '{3'd7, 32'hFFF00093, 64'h0000_0000_0000_0000, 1'b1};

    do_reset();

    // Table vectors: one beat at a time, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid  = 1'b1;
      in_immsrc = vecs[i].src;
      in_instr  = vecs[i].instr;
      in_tag    = i[5:0];
      @(negedge clk);
      check("vec_pre_valid", {63'd0, out_valid}, 64'd0);
      check("vec_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (vecs[i].ill) ill_seen++;
      @(negedge clk);
      check("vec_valid", {63'd0, out_valid}, 64'd1);
      check("vec_imm", out_imm, vecs[i].imm);
      check("vec_tag", {58'd0, out_tag}, 64'(i));
      check("vec_flags", {62'd0, out_illegal, out_fused}, {62'd0, vecs[i].ill, 1'b0});
      @(posedge clk);
      #1;
    end
    check("vec_illegal_count", {56'd0, illegal_count}, 64'd1);

    // Backpressure: two beats fill the buffer, the third stalls.
    sb_en     = 1'b1;
    out_ready = 1'b0;
    send(3'd0, 32'h00100093, 6'd1, 1'b0, 1'b1, mk(64'd1, 6'd1, 1'b0, 1'b0));
    send(3'd3, 32'h123452B7, 6'd2, 1'b0, 1'b1, mk(64'h1234_5000, 6'd2, 1'b0, 1'b0));
    @(negedge clk);
    check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_head_imm", out_imm, 64'd1);
    fork
      send(3'd4, 32'h008000EF, 6'd3, 1'b0, 1'b1, mk(64'd8, 6'd3, 1'b0, 1'b0));
      begin
        repeat (3) @(negedge clk);
        check("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_imm", out_imm, 64'd1);
        check("bp_hold_tag", {58'd0, out_tag}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("bp");

    // fuse hint: merged beat when fusion is built in, ignored otherwise.
`ifdef IMM_FUSE_EN
    send(3'd3, 32'h123452B7, 6'd20, 1'b1, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    send(3'd0, 32'h67828293, 6'd21, 1'b1, 1'b1, mk(64'h1234_5678, 6'd21, 1'b0, 1'b1));
    wait_drain("fuse_pos");
    send(3'd3, 32'h123452B7, 6'd22, 1'b1, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    send(3'd0, 32'h80028293, 6'd23, 1'b1, 1'b1, mk(64'h1234_4800, 6'd23, 1'b0, 1'b1));
    wait_drain("fuse_neg");
    send(3'd3, 32'h123452B7, 6'd24, 1'b1, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    sbq.push_back(mk(64'h1234_5000, 6'd24, 1'b0, 1'b0));
    send(3'd2, 32'h0020A423, 6'd25, 1'b0, 1'b1, mk(64'd8, 6'd25, 1'b0, 1'b0));
    wait_drain("fuse_break");
    send(3'd3, 32'h123452B7, 6'd26, 1'b1, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("fuse_flush_no_out", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    send(3'd0, 32'h67828293, 6'd27, 1'b1, 1'b1, mk(64'h678, 6'd27, 1'b0, 1'b0));
    wait_drain("fuse_after_flush");
`else
    send(3'd3, 32'h123452B7, 6'd20, 1'b1, 1'b1, mk(64'h1234_5000, 6'd20, 1'b0, 1'b0));
    send(3'd0, 32'h67828293, 6'd21, 1'b1, 1'b1, mk(64'h678, 6'd21, 1'b0, 1'b0));
    wait_drain("nofuse");
`endif

    // Flush drops the buffered beat and the one offered in the same cycle.
    out_ready = 1'b0;
    send(3'd0, 32'h00100093, 6'd30, 1'b0, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    @(negedge clk);
    check("fl_valid_before", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_immsrc = 3'd0;
    in_instr  = 32'h7FF00093;
    in_tag    = 6'd31;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("fl_valid_after", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Illegal selects: counter saturates and survives flush.
    for (int i = 0; i < 300; i++) begin
      send(3'd7, $urandom, i[5:0], 1'b0, 1'b1, mk(64'd0, i[5:0], 1'b1, 1'b0));
      if (i == 9) check("ill_count_mid", {56'd0, illegal_count}, 64'(ill_seen));
    end
    check("ill_count_sat", {56'd0, illegal_count}, 64'd255);
    wait_drain("ill");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("ill_count_flush", {56'd0, illegal_count}, 64'd255);

    // Reset with two beats buffered clears everything at once.
    sb_en     = 1'b0;
    out_ready = 1'b0;
    send(3'd0, 32'h00100093, 6'd40, 1'b0, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    send(3'd0, 32'h00100093, 6'd41, 1'b0, 1'b0, mk(64'd0, 6'd0, 1'b0, 1'b0));
    check("rst2_valid_before", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("rst2_valid_now", {63'd0, out_valid}, 64'd0);
    check("rst2_count_now", {56'd0, illegal_count}, 64'd0);
    check("rst2_imm_now", out_imm, 64'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
